// File: rtl/rtc_bus_pkg.sv
// Shared state encoding, default strobe timing and counter sizing for the RTC bus master.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_SETUP,
        ADDR_STROBE,
        ADDR_HOLD,
        WAIT_WDATA,
        DATA_SETUP,
        DATA_STROBE,
        DATA_HOLD,
        RECOVER
    } state_t;

    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 4;
    localparam int DEF_T_HOLD  = 2;
    localparam int DEF_T_RECOV = 4;

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rtc_bus_master_if.sv
// Command, write-data, read-data, pad and interrupt signals of the RTC bus master.
interface rtc_bus_master_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;
    logic              cs_n;
    logic              ad;
    logic              rd_n;
    logic              wr_n;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_in;
    logic              irq_n;
    logic              irq_clear;
    logic              irq_pending;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, bus_in, irq_n, irq_clear,
        output cmd_ready, wdata_ready, rdata, rdata_valid, busy, done,
               cs_n, ad, rd_n, wr_n, bus_out, bus_oe, irq_pending
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, bus_in, irq_n, irq_clear,
        input  cmd_ready, wdata_ready, rdata, rdata_valid, busy, done,
               cs_n, ad, rd_n, wr_n, bus_out, bus_oe, irq_pending
    );
endinterface

// File: rtl/rtc_irq_sync.sv
// Two-flop synchroniser on the async active-low RTC interrupt; a synchronised falling edge
// sets a sticky flag, cleared by irq_clear (set wins). Flag rises 3 cycles after the pin falls.
module rtc_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_n,
    input  logic irq_clear,
    output logic irq_pending
);
    logic [2:0] r_sync;
    logic       r_pending;
    logic       w_fall;

    // r_sync[1:0] is the synchroniser, r_sync[2] only delays it for edge detection
    assign w_fall      = r_sync[2] & ~r_sync[1];
    assign irq_pending = r_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= 3'b111;
            r_pending <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], irq_n};
            if (w_fall)
                r_pending <= 1'b1;
            else if (irq_clear)
                r_pending <= 1'b0;
        end
    end
endmodule

// File: rtl/rtc_bus_master.sv
// Burst master for the RTC multiplexed AD bus: one command = cmd_len+1 beats, each beat
// address-latch then data strobe with programmable timing; commands are ignored while busy.
module rtc_bus_master
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4,
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int T_RECOV = DEF_T_RECOV
) (
    input  logic clk,
    input  logic reset,
    rtc_bus_master_if.master bus
);
    localparam int CNT_W     = cnt_width(T_SETUP, T_PULSE, T_HOLD, T_RECOV);
    localparam bit RECOV_ONE = (T_RECOV == 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_bus_out;
    logic [LEN_W-1:0]  r_left;
    logic              r_write;
    logic              r_cs_n, r_ad, r_rd_n, r_wr_n, r_oe;
    logic              r_rdata_valid, r_done, r_busy, r_cmd_ready;

    logic              w_cnt_zero, w_last_beat, w_wdata_take, w_done_next, w_irq_pending;
    logic [DATA_W-1:0] w_next_addr;

    assign w_cnt_zero   = (r_cnt == '0);
    assign w_last_beat  = (r_left == '0);
    assign w_next_addr  = r_addr + DATA_W'(1);
    // Write data is taken in the last ADDR_HOLD cycle when already present, so WAIT_WDATA costs nothing
    assign w_wdata_take = r_write && bus.wdata_valid &&
                          ((r_state == ADDR_HOLD && w_cnt_zero) || r_state == WAIT_WDATA);
    assign w_done_next  = w_last_beat &&
                          ((r_state == DATA_HOLD && w_cnt_zero && RECOV_ONE) ||
                           (r_state == RECOVER && r_cnt == CNT_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_rdata       <= '0;
            r_bus_out     <= '0;
            r_left        <= '0;
            r_write       <= 1'b0;
            r_cs_n        <= 1'b1;
            r_ad          <= 1'b1;
            r_rd_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_oe          <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_cmd_ready   <= 1'b1;
        end else begin
            r_rdata_valid <= 1'b0;
            r_done        <= w_done_next;
            if (!w_cnt_zero)
                r_cnt <= r_cnt - CNT_W'(1);
            case (r_state)
                IDLE: if (bus.cmd_valid) begin
                    r_addr      <= bus.cmd_addr;
                    r_left      <= bus.cmd_len;
                    r_write     <= bus.cmd_write;
                    r_busy      <= 1'b1;
                    r_cmd_ready <= 1'b0;
                    r_state     <= ADDR_SETUP;
                    r_cnt       <= CNT_W'(T_SETUP - 1);
                    r_cs_n      <= 1'b0;
                    r_ad        <= 1'b0;
                    r_oe        <= 1'b1;
                    r_bus_out   <= bus.cmd_addr;
                end
                ADDR_SETUP: if (w_cnt_zero) begin
                    r_state <= ADDR_STROBE;
                    r_cnt   <= CNT_W'(T_PULSE - 1);
                    r_wr_n  <= 1'b0;
                end
                ADDR_STROBE: if (w_cnt_zero) begin
                    r_state <= ADDR_HOLD;
                    r_cnt   <= CNT_W'(T_HOLD - 1);
                    r_wr_n  <= 1'b1;
                end
                ADDR_HOLD, WAIT_WDATA: if (r_state == WAIT_WDATA || w_cnt_zero) begin
                    r_ad <= 1'b1;
                    if (!r_write || w_wdata_take) begin
                        r_state   <= DATA_SETUP;
                        r_cnt     <= CNT_W'(T_SETUP - 1);
                        r_oe      <= r_write;
                        if (r_write)
                            r_bus_out <= bus.wdata;
                    end else begin
                        r_state <= WAIT_WDATA;
                        r_oe    <= 1'b0;
                    end
                end
                DATA_SETUP: if (w_cnt_zero) begin
                    r_state <= DATA_STROBE;
                    r_cnt   <= CNT_W'(T_PULSE - 1);
                    r_rd_n  <= r_write;
                    r_wr_n  <= !r_write;
                end
                DATA_STROBE: if (w_cnt_zero) begin
                    r_state <= DATA_HOLD;
                    r_cnt   <= CNT_W'(T_HOLD - 1);
                    r_rd_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    if (!r_write) begin
                        r_rdata       <= bus.bus_in;
                        r_rdata_valid <= 1'b1;
                    end
                end
                DATA_HOLD: if (w_cnt_zero) begin
                    r_state <= RECOVER;
                    r_cnt   <= CNT_W'(T_RECOV - 1);
                    r_cs_n  <= 1'b1;
                    r_oe    <= 1'b0;
                end
                RECOVER: if (w_cnt_zero) begin
                    if (!w_last_beat) begin
                        r_left    <= r_left - LEN_W'(1);
                        r_addr    <= w_next_addr;
                        r_state   <= ADDR_SETUP;
                        r_cnt     <= CNT_W'(T_SETUP - 1);
                        r_cs_n    <= 1'b0;
                        r_ad      <= 1'b0;
                        r_oe      <= 1'b1;
                        r_bus_out <= w_next_addr;
                    end else begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    rtc_irq_sync u_irq (
        .clk         (clk),
        .reset       (reset),
        .irq_n       (bus.irq_n),
        .irq_clear   (bus.irq_clear),
        .irq_pending (w_irq_pending)
    );

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.wdata_ready = w_wdata_take;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.cs_n        = r_cs_n;
    assign bus.ad          = r_ad;
    assign bus.rd_n        = r_rd_n;
    assign bus.wr_n        = r_wr_n;
    assign bus.bus_out     = r_bus_out;
    assign bus.bus_oe      = r_oe;
    assign bus.irq_pending = w_irq_pending;
endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed bench for rtc_bus_master: default-timing DUT plus a minimum-timing DUT.
module tb_rtc_bus_master;
    localparam int DW   = 8;
    localparam int LW   = 4;
    localparam int LOGN = 128;
    localparam int S_WR = 0, S_RD = 1, S_CS = 2, S_OE = 3, S_AD = 4;
    localparam int S_RV = 5, S_DONE = 6, S_RDY = 7, S_WRDY = 8, NSIG = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rtc_bus_master_if #(.DATA_W(DW), .LEN_W(LW)) bif ();
    rtc_bus_master_if #(.DATA_W(DW), .LEN_W(LW)) fif ();

    rtc_bus_master #(.DATA_W(DW), .LEN_W(LW), .T_SETUP(2), .T_PULSE(4), .T_HOLD(2), .T_RECOV(4))
        dut (.clk(clk), .reset(rst), .bus(bif.master));
    rtc_bus_master #(.DATA_W(DW), .LEN_W(LW), .T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_RECOV(1))
        dut_fast (.clk(clk), .reset(rst), .bus(fif.master));

    int           n_checks, n_fail;
    int           cyc, wk, hold_lo, hold_hi;
    bit           src_en;
    logic [7:0]   lat_addr;
    logic [127:0] lg [NSIG];
    logic [7:0]   log_bus_out [LOGN];
    logic [7:0]   log_rdata [LOGN];

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        case (a)
            8'h21:   return 8'h45;
            8'hFF:   return 8'hA5;
            8'h00:   return 8'h5A;
            default: return 8'hEE;
        endcase
    endfunction

    function automatic logic [127:0] rng(input int lo, input int hi);
        logic [127:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic drive_cycle();
        bif.wdata       = 8'h10 + 8'(wk);
        bif.wdata_valid = src_en && !(cyc >= hold_lo && cyc <= hold_hi);
        bif.bus_in      = rd_model(lat_addr);
    endtask

    task automatic sample();
        @(negedge clk);
        if (cyc < LOGN) begin
            lg[S_WR][cyc]    = bif.wr_n;
            lg[S_RD][cyc]    = bif.rd_n;
            lg[S_CS][cyc]    = bif.cs_n;
            lg[S_OE][cyc]    = bif.bus_oe;
            lg[S_AD][cyc]    = bif.ad;
            lg[S_RV][cyc]    = bif.rdata_valid;
            lg[S_DONE][cyc]  = bif.done;
            lg[S_RDY][cyc]   = bif.cmd_ready;
            lg[S_WRDY][cyc]  = bif.wdata_ready;
            log_bus_out[cyc] = bif.bus_out;
            log_rdata[cyc]   = bif.rdata;
        end
        if (bif.ad == 1'b0 && bif.wr_n == 1'b0) lat_addr = bif.bus_out;
        if (bif.wdata_ready) wk++;
    endtask

    task automatic start_cmd(input logic wr, input logic [7:0] a, input logic [3:0] len);
        for (int i = 0; i < NSIG; i++) lg[i] = '0;
        @(posedge clk); #1;
        cyc = 0; wk = 0; lat_addr = 8'h00;
        bif.cmd_valid = 1'b1; bif.cmd_write = wr; bif.cmd_addr = a; bif.cmd_len = len;
        drive_cycle();
        sample();
    endtask

    task automatic run_to(input int last);
        while (cyc < last) begin
            @(posedge clk); #1;
            cyc++;
            bif.cmd_valid = 1'b0;
            drive_cycle();
            sample();
        end
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        #12;
        obs = {bif.cs_n, bif.rd_n, bif.wr_n, bif.ad, bif.bus_oe, bif.rdata_valid,
               bif.done, bif.busy, bif.cmd_ready, bif.irq_pending, bif.wdata_ready};
        n_checks++;
        if (obs !== 11'b11110000100) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", obs, 11'b11110000100);
        end
        n_checks++;
        if (bif.bus_out !== 8'h00 || bif.rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: bus_out %h rdata %h want 00 00", bif.bus_out, bif.rdata);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bif.cmd_ready !== 1'b1 || bif.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: cmd_ready %b busy %b want 1 0", bif.cmd_ready, bif.busy);
        end
    endtask

    task automatic test_single_read();
        logic [127:0] all, exp;
        int bad;
        src_en = 1'b0; hold_lo = -1; hold_hi = -1;
        start_cmd(1'b0, 8'h21, 4'd0);
        run_to(21);
        all = rng(0, 21);
        exp = all & ~rng(3, 6);
        n_checks++;
        if (lg[S_WR] !== exp) begin n_fail++; $display("FAIL rd1_wr_n: got %h want %h", lg[S_WR], exp); end
        exp = all & ~rng(11, 14);
        n_checks++;
        if (lg[S_RD] !== exp) begin n_fail++; $display("FAIL rd1_rd_n: got %h want %h", lg[S_RD], exp); end
        exp = all & ~rng(1, 16);
        n_checks++;
        if (lg[S_CS] !== exp) begin n_fail++; $display("FAIL rd1_cs_n: got %h want %h", lg[S_CS], exp); end
        exp = rng(1, 8);
        n_checks++;
        if (lg[S_OE] !== exp) begin n_fail++; $display("FAIL rd1_oe: got %h want %h", lg[S_OE], exp); end
        n_checks++;
        if (log_bus_out[3] !== 8'h21 || log_bus_out[6] !== 8'h21) begin
            n_fail++; $display("FAIL rd1_addr: got %h/%h want 21", log_bus_out[3], log_bus_out[6]);
        end
        exp = rng(15, 15);
        n_checks++;
        if (lg[S_RV] !== exp) begin n_fail++; $display("FAIL rd1_rvalid: got %h want %h", lg[S_RV], exp); end
        n_checks++;
        if (log_rdata[15] !== 8'h45) begin n_fail++; $display("FAIL rd1_rdata: got %h want 45", log_rdata[15]); end
        exp = rng(20, 20);
        n_checks++;
        if (lg[S_DONE] !== exp) begin n_fail++; $display("FAIL rd1_done: got %h want %h", lg[S_DONE], exp); end
        exp = rng(0, 0) | rng(21, 21);
        n_checks++;
        if (lg[S_RDY] !== exp) begin n_fail++; $display("FAIL rd1_ready: got %h want %h", lg[S_RDY], exp); end
        bad = 0;
        for (int c = 0; c <= 21; c++)
            if (!lg[S_RD][c] && (!lg[S_WR][c] || lg[S_OE][c])) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL rd1_exclusive: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_write_burst();
        logic [127:0] all, exp;
        src_en = 1'b1; hold_lo = 28; hold_hi = 32;
        start_cmd(1'b1, 8'h22, 4'd2);
        run_to(67);
        src_en = 1'b0; bif.wdata_valid = 1'b0;
        all = rng(0, 67);
        exp = all & ~(rng(3, 6) | rng(11, 14) | rng(23, 26) | rng(36, 39) | rng(48, 51) | rng(56, 59));
        n_checks++;
        if (lg[S_WR] !== exp) begin n_fail++; $display("FAIL wr_wr_n: got %h want %h", lg[S_WR], exp); end
        exp = all & ~(rng(1, 16) | rng(21, 41) | rng(46, 61));
        n_checks++;
        if (lg[S_CS] !== exp) begin n_fail++; $display("FAIL wr_cs_n: got %h want %h", lg[S_CS], exp); end
        exp = rng(1, 16) | rng(21, 28) | rng(34, 41) | rng(46, 61);
        n_checks++;
        if (lg[S_OE] !== exp) begin n_fail++; $display("FAIL wr_oe: got %h want %h", lg[S_OE], exp); end
        exp = all & ~(rng(1, 8) | rng(21, 28) | rng(46, 53));
        n_checks++;
        if (lg[S_AD] !== exp) begin n_fail++; $display("FAIL wr_ad: got %h want %h", lg[S_AD], exp); end
        exp = rng(8, 8) | rng(33, 33) | rng(53, 53);
        n_checks++;
        if (lg[S_WRDY] !== exp) begin n_fail++; $display("FAIL wr_wready: got %h want %h", lg[S_WRDY], exp); end
        n_checks++;
        if ({log_bus_out[3], log_bus_out[23], log_bus_out[48]} !== 24'h222324) begin
            n_fail++; $display("FAIL wr_addrs: got %h %h %h want 22 23 24", log_bus_out[3], log_bus_out[23], log_bus_out[48]);
        end
        n_checks++;
        if ({log_bus_out[11], log_bus_out[36], log_bus_out[59]} !== 24'h101112) begin
            n_fail++; $display("FAIL wr_data: got %h %h %h want 10 11 12", log_bus_out[11], log_bus_out[36], log_bus_out[59]);
        end
        exp = rng(65, 65);
        n_checks++;
        if (lg[S_DONE] !== exp) begin n_fail++; $display("FAIL wr_done: got %h want %h", lg[S_DONE], exp); end
    endtask

    task automatic test_read_wrap();
        logic [127:0] all, exp;
        src_en = 1'b0; hold_lo = -1; hold_hi = -1;
        start_cmd(1'b0, 8'hFF, 4'd1);
        run_to(42);
        all = rng(0, 42);
        n_checks++;
        if (log_bus_out[3] !== 8'hFF || log_bus_out[23] !== 8'h00) begin
            n_fail++; $display("FAIL wrap_addr: got %h %h want ff 00", log_bus_out[3], log_bus_out[23]);
        end
        exp = all & ~(rng(11, 14) | rng(31, 34));
        n_checks++;
        if (lg[S_RD] !== exp) begin n_fail++; $display("FAIL wrap_rd_n: got %h want %h", lg[S_RD], exp); end
        exp = rng(15, 15) | rng(35, 35);
        n_checks++;
        if (lg[S_RV] !== exp) begin n_fail++; $display("FAIL wrap_rvalid: got %h want %h", lg[S_RV], exp); end
        n_checks++;
        if ({log_rdata[15], log_rdata[20], log_rdata[35]} !== 24'hA5A55A) begin
            n_fail++; $display("FAIL wrap_rdata: got %h %h %h want a5 a5 5a", log_rdata[15], log_rdata[20], log_rdata[35]);
        end
        exp = rng(40, 40);
        n_checks++;
        if (lg[S_DONE] !== exp) begin n_fail++; $display("FAIL wrap_done: got %h want %h", lg[S_DONE], exp); end
    endtask

    task automatic test_reset_mid_burst();
        int dones;
        src_en = 1'b1; hold_lo = -1; hold_hi = -1;
        start_cmd(1'b1, 8'h30, 4'd0);
        run_to(12);
        n_checks++;
        if (lg[S_WR][12] !== 1'b0 || log_bus_out[12] !== 8'h10) begin
            n_fail++; $display("FAIL mid_strobe: wr_n %b data %h want 0 10", lg[S_WR][12], log_bus_out[12]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bif.wr_n, bif.cs_n, bif.bus_oe, bif.busy} !== 4'b1100) begin
            n_fail++; $display("FAIL mid_abort: wr_n/cs_n/oe/busy got %b want 1100", {bif.wr_n, bif.cs_n, bif.bus_oe, bif.busy});
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; src_en = 1'b0; bif.wdata_valid = 1'b0;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
        n_checks++;
        if (dones !== 0 || bif.cmd_ready !== 1'b1 || bif.cs_n !== 1'b1) begin
            n_fail++; $display("FAIL mid_after: done pulses %0d cmd_ready %b cs_n %b want 0 1 1", dones, bif.cmd_ready, bif.cs_n);
        end
    endtask

    task automatic test_irq();
        logic [3:0] seen;
        @(posedge clk); #1;
        bif.irq_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin @(posedge clk); #1; bif.irq_n = 1'b1; end
            else if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            seen[k] = bif.irq_pending;
        end
        n_checks++;
        if (seen !== 4'b1000) begin n_fail++; $display("FAIL irq_latency: got %b want 1000", seen); end
        repeat (3) @(posedge clk);
        #1; bif.irq_clear = 1'b1;
        @(posedge clk); #1; bif.irq_clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bif.irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", bif.irq_pending); end
        repeat (3) @(posedge clk);
        #1; bif.irq_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; bif.irq_clear = 1'b1;
        @(posedge clk); #1; bif.irq_clear = 1'b0; bif.irq_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bif.irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b want 1", bif.irq_pending); end
    endtask

    task automatic test_fast_timing();
        logic [9:0] fwr, frd, fcs, frv, fdone, frdy;
        logic [7:0] frdata;
        frdata = 8'h00;
        @(posedge clk); #1;
        fif.cmd_valid = 1'b1; fif.cmd_write = 1'b0; fif.cmd_addr = 8'h21; fif.cmd_len = 4'd0;
        fif.bus_in = 8'h45;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin @(posedge clk); #1; fif.cmd_valid = 1'b0; end
            @(negedge clk);
            fwr[c] = fif.wr_n; frd[c] = fif.rd_n; fcs[c] = fif.cs_n;
            frv[c] = fif.rdata_valid; fdone[c] = fif.done; frdy[c] = fif.cmd_ready;
            if (c == 6) frdata = fif.rdata;
        end
        n_checks++;
        if (fwr !== 10'h3FB || frd !== 10'h3DF) begin
            n_fail++; $display("FAIL fast_strobes: wr_n %h rd_n %h want 3fb 3df", fwr, frd);
        end
        n_checks++;
        if (fcs !== 10'h381) begin n_fail++; $display("FAIL fast_cs_n: got %h want 381", fcs); end
        n_checks++;
        if (frv !== 10'h040 || frdata !== 8'h45) begin
            n_fail++; $display("FAIL fast_rdata: valid %h data %h want 040 45", frv, frdata);
        end
        n_checks++;
        if (fdone !== 10'h080 || frdy !== 10'h301) begin
            n_fail++; $display("FAIL fast_done: done %h ready %h want 080 301", fdone, frdy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        n_checks = 0; n_fail = 0; cyc = 0; wk = 0; hold_lo = -1; hold_hi = -1;
        src_en = 1'b0; lat_addr = 8'h00;
        bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0; bif.cmd_len = '0;
        bif.wdata = '0; bif.wdata_valid = 1'b0; bif.bus_in = '0; bif.irq_n = 1'b1; bif.irq_clear = 1'b0;
        fif.cmd_valid = 1'b0; fif.cmd_write = 1'b0; fif.cmd_addr = '0; fif.cmd_len = '0;
        fif.wdata = '0; fif.wdata_valid = 1'b0; fif.bus_in = '0; fif.irq_n = 1'b1; fif.irq_clear = 1'b0;
        test_reset();
        test_single_read();
        test_write_burst();
        test_read_wrap();
        test_reset_mid_burst();
        test_irq();
        test_fast_timing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_bus_master.md
Name: rtc_bus_master

Overview:
- Parametrised master for the multiplexed address/data parallel bus of the real-time-clock chip (AD, CS, RD, WR lines).
- Replaces fixed single-register access with configurable strobe timing and burst transfers of consecutive registers.
- Adds a synchronised, sticky IRQ flag.
- Sits between the PicoBlaze register-exchange logic and the top-level tristate pad; the top level drives the inout pin as `bus_oe ? bus_out : 'z` and feeds the pin back to `bus_in`.

Parameters:
- DATA_W, 8, width of address/data bus and register values
- LEN_W, 4, width of burst length field; burst beats = cmd_len+1 (1..2^LEN_W)
- T_SETUP, 2, cycles of each setup phase (≥1)
- T_PULSE, 4, cycles each strobe is held low (≥1)
- T_HOLD, 2, cycles of each hold phase (≥1)
- T_RECOV, 4, cycles with cs_n high between beats (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  transfer request
- cmd_ready  out  1  high in IDLE; command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  DATA_W  first RTC register address
- cmd_len  in  LEN_W  beats minus one
- wdata  in  DATA_W  write data for current beat
- wdata_valid  in  1  wdata present
- wdata_ready  out  1  one-cycle pulse when the beat's wdata is consumed
- rdata  out  DATA_W  read data, held until next read beat
- rdata_valid  out  1  one-cycle pulse per read beat
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle pulse in the final RECOVER cycle of the burst
- cs_n  out  1  chip select, active low
- ad  out  1  0=address phase, 1=data phase
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low (also latches address)
- bus_out  out  DATA_W  value driven to pad
- bus_oe  out  1  pad output enable
- bus_in  in  DATA_W  pad input
- irq_n  in  1  RTC interrupt, active low, asynchronous
- irq_clear  in  1  clears irq_pending
- irq_pending  out  1  sticky interrupt flag

Behaviour:
- Reset (async):
  - State IDLE.
  - cs_n=rd_n=wr_n=1, ad=1, bus_oe=0, bus_out=0.
  - rdata=0; rdata_valid=wdata_ready=done=busy=0.
  - cmd_ready=1 (reset deasserted); irq_pending=0; sync flops=1 (inactive).
  - Reset mid-burst aborts immediately; no completion pulse.
- Acceptance: cmd_addr, cmd_len and cmd_write are latched. Bus activity starts the next cycle.
- Per-beat states, each timed by a shared down-counter:
  - ADDR_SETUP (T_SETUP): cs_n=0, ad=0, bus_oe=1, bus_out=addr.
  - ADDR_STROBE (T_PULSE): as ADDR_SETUP, plus wr_n=0.
  - ADDR_HOLD (T_HOLD): wr_n=1, address still driven.
  - WAIT_WDATA (write only): ad=1, bus_oe=0.
    - Stays until wdata_valid.
    - When wdata_valid is seen: wdata_ready pulses and wdata is latched in that cycle.
    - Zero extra cycles if wdata_valid is already high.
  - DATA_SETUP (T_SETUP): ad=1.
    - Write: bus_oe=1, bus_out=latched wdata.
    - Read: bus_oe=0.
  - DATA_STROBE (T_PULSE): rd_n=0 (read) or wr_n=0 (write).
    - Read: bus_in is captured into rdata at the clock edge ending the last strobe cycle.
  - DATA_HOLD (T_HOLD): strobes high, write data still driven.
    - Read: rdata_valid pulses in the first DATA_HOLD cycle.
  - RECOVER (T_RECOV): cs_n=1, bus_oe=0.
    - Last cycle: if beats remain, addr += 1 (mod 2^DATA_W) and go to ADDR_SETUP. Otherwise pulse done and go to IDLE.
- rd_n and wr_n are never low together. bus_oe=0 whenever rd_n=0.
- Read beat latency with defaults: accept at cycle 0, cs_n falls at cycle 1, rdata_valid at cycle 15, done at cycle 20, cmd_ready at cycle 21. Each further beat adds 20 cycles.
- cmd_valid while busy is ignored; it is not queued.
- IRQ:
  - irq_n passes through a 2-flop synchroniser.
  - irq_pending is set on a synchronised high→low edge.
  - irq_pending is cleared by irq_clear; set wins if both occur in the same cycle.
  - irq_pending is independent of bus activity.

Decomposition:
- Package rtc_bus_pkg:
  - state enum (IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, WAIT_WDATA, DATA_SETUP, DATA_STROBE, DATA_HOLD, RECOVER);
  - default timing constants;
  - counter width function clog2(max(T_*)+1).
- Sub-module rtc_irq_sync: synchroniser, falling-edge detect, sticky flag with set priority.

Test Plan:
- Single read, addr 0x21, bus model returns 0x45:
  - wr_n low cycles 3–6 with bus_out=0x21;
  - rd_n low cycles 11–14;
  - rdata=0x45 with rdata_valid at cycle 15;
  - done at cycle 20.
- Write burst addr 0x22, len 2, wdata 0x10/0x11/0x12, with wdata_valid withheld 5 cycles on beat 2:
  - addresses 0x22/0x23/0x24 latched;
  - data beats drive 0x10/0x11/0x12;
  - beat 2 stretched by exactly 5 WAIT_WDATA cycles;
  - three wdata_ready pulses.
- Read burst addr 0xFF, len 1: second beat address wraps to 0x00; two rdata_valid pulses.
- Reset asserted during DATA_STROBE of a write: in the same cycle wr_n=1, cs_n=1, bus_oe=0; no done pulse; cmd_ready=1 after release.
- irq_n pulsed low 3 cycles: irq_pending rises 3 cycles after the falling edge; irq_clear coinciding with a new edge leaves irq_pending=1.
- Parameter set T_SETUP=1, T_PULSE=1, T_HOLD=1, T_RECOV=1: single read completes with done at cycle 7; strobe widths are 1 cycle.
